mdu_hilo_writer: RTL and testbench
==================================

Name: mdu_hilo_writer

Overview:
- Multicycle multiply/divide unit in the EX stage; the producer side of the HI/LO write interface of the register file.
- Executes MULT, MULTU, DIV and DIVU iteratively.
- Holds the pipeline with `busy` while it computes.
- Issues a single-cycle `hi_we`/`lo_we` write with the 64-bit result split into HI and LO.

Parameters:
- `DATA_W`, default 32: operand and HI/LO width. Only 32 is supported.
- `ITER`, default 32: iteration cycles per operation. Must equal `DATA_W`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: EX holds a mult/div instruction. Held high until `busy` falls.
- `op` in 2: operation. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a` in 32: rs operand, the dividend or multiplicand.
- `src_b` in 32: rt operand, the divisor or multiplier.
- `cancel` in 1: flush from exception or branch. Kills the operation in progress.
- `busy` out 1: stall request to the pipeline.
- `hi_we` out 1: HI write enable.
- `lo_we` out 1: LO write enable.
- `hi_wdata` out 32: HI write data. Remainder for DIV/DIVU, upper product for MULT/MULTU.
- `lo_wdata` out 32: LO write data. Quotient for DIV/DIVU, lower product for MULT/MULTU.

Behaviour:
- Reset and outputs:
  - One clock (`clk`). Reset `rst` is synchronous and active-high.
  - On `rst`: state goes to IDLE, counter = 0, `hi_we` = `lo_we` = 0, `hi_wdata` = `lo_wdata` = 0.
  - `rst` mid-operation aborts it with no write.
- States are IDLE, MUL, DIV, DONE.
- IDLE:
  - `start`=1 with `cancel`=0 accepts the operation (cycle T). The block latches |a|, |b|, sign_a, sign_b and `op`; absolute values apply to signed ops only. Counter clears to 0.
  - Next state is MUL for op 0x, or DIV for op 1x.
  - Exception: for DIV/DIVU with `src_b`==0, next state is DONE directly.
- MUL: shift-add, one multiplier bit per cycle over a 64-bit accumulator. Leaves after `ITER` cycles (T+1..T+32) for DONE.
- DIV: restoring division with a 33-bit partial remainder, one quotient bit per cycle. Leaves after `ITER` cycles for DONE.
- DONE:
  - Lasts one cycle (T+33, or T+1 for divide-by-zero).
  - `hi_we` = `lo_we` = 1 and the data outputs are valid in that cycle. Next state is IDLE.
  - `start` is ignored in DONE, because the same instruction is still in EX.
- `busy` (combinational) = (state==IDLE && `start` && !`cancel`) || state==MUL || state==DIV.
  - High T..T+32; low in DONE.
- `hi_we`/`lo_we` are 0 in every state except DONE. `hi_wdata`/`lo_wdata` are registered and hold their last value outside DONE.
- Signed fixup, applied on entry to DONE:
  - MULT: negate the 64-bit product if sign_a^sign_b.
  - DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. The quotient wraps and no trap is raised.
- Divide by zero (DIV or DIVU): hi = `src_a` as latched, lo = 0xFFFFFFFF.
- Cancel:
  - `cancel` in MUL, DIV or DONE sends the state to IDLE on the next edge. No write occurs, including when `cancel` arrives in the DONE cycle.
  - `start`+`cancel` together in IDLE is not accepted.
  - `cancel` has priority over `start`; `rst` has priority over both.
- Operands are sampled only at acceptance. Later changes on `src_a`/`src_b` are ignored.

Decomposition:
- Shared package `mdu_pkg` contains:
  - op encodings `MDU_MULT`/`MDU_MULTU`/`MDU_DIV`/`MDU_DIVU`
  - the state encoding
  - `DATA_W`
- One sub-module: `mdu_div_step`, a combinational single restoring-division step (33-bit compare/subtract, shift-in of a quotient bit). It is instantiated once in the top.

Test Plan:
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF, `start` at T → `busy` high T..T+32; at T+33 `hi_we`=`lo_we`=1, hi=0xFFFFFFFE, lo=0x00000001; write enables low at T+34.
2. MULT 0xFFFFFFFD × 0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
3. Divide results:
   - DIV 0xFFFFFFF9 / 0x00000002 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU 100 / 7 → lo=0x0000000E, hi=0x00000002.
   - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU 0x00001234 / 0 → `busy` high at T only; DONE at T+1 with hi=0x00001234, lo=0xFFFFFFFF.
5. Cancel and DONE-cycle behaviour:
   - DIV with `cancel` at T+10 → `busy` low at T+11, no write enable ever; `start` at T+11 is accepted and its result is correct.
   - `start` held high through DONE → exactly one write, no re-acceptance.
6. MULTU with `rst` at T+5 → from T+6: IDLE, `busy`=0, `hi_wdata`=`lo_wdata`=0, no write enable; the next operation completes normally.

Source files
------------

// File: rtl/mdu_hilo_writer_pkg.sv
// Shared definitions for the multiply/divide unit.
// Op encodings, FSM states and datapath width.
package mdu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_hilo_writer_if.sv
// EX-side request and HI/LO write bundle.
// master drives the request, slave is the MDU.
interface mdu_hilo_writer_if;
  import mdu_pkg::*;

  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              cancel;
  logic              busy;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] hi_wdata;
  logic [DATA_W-1:0] lo_wdata;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, hi_we, lo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, hi_we, lo_we, hi_wdata, lo_wdata
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next
// dividend bit, trial-subtract, emit a quotient bit.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] sub;
  logic       ge;

  assign shifted = {rem_i, quo_i[W-1]};
  assign ge      = shifted >= {1'b0, dvs_i};
  assign sub     = shifted - {1'b0, dvs_i};
  assign rem_o   = W'(ge ? sub : shifted);
  assign quo_o   = {quo_i[W-2:0], ge};

endmodule

// File: rtl/mdu_hilo_writer.sv
// Iterative MULT/MULTU/DIV/DIVU unit in EX.
// Stalls with busy, then writes HI/LO for one cycle.
module mdu_hilo_writer #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input logic              clk,
  input logic              rst,
  mdu_hilo_writer_if.slave bus
);
  import mdu_pkg::*;

  localparam int W = DATA_W;

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q, op_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             sa_q, sa_d, sb_q, sb_d;

  logic             is_signed, last, busy, we;
  logic [W-1:0]     abs_a, abs_b;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_n, prod;
  logic [W-1:0]     rem_n, quo_n, rem_f, quo_f;

  assign is_signed = ~bus.op[0];
  assign abs_a = (is_signed && bus.src_a[W-1])
               ? -bus.src_a : bus.src_a;
  assign abs_b = (is_signed && bus.src_b[W-1])
               ? -bus.src_b : bus.src_b;

  // acc = {partial product, remaining multiplier}
  assign mul_sum = {1'b0, acc_q[2*W-1:W]}
                 + {1'b0, acc_q[0] ? a_q : {W{1'b0}}};
  assign mul_n   = {mul_sum, acc_q[W-1:1]};
  assign prod    = (op_q == MDU_MULT && (sa_q ^ sb_q))
                 ? -mul_n : mul_n;

  // acc = {partial remainder, dividend/quotient}
  mdu_div_step #(.W(W)) u_step (
    .rem_i (acc_q[2*W-1:W]),
    .quo_i (acc_q[W-1:0]),
    .dvs_i (b_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  assign quo_f = (op_q == MDU_DIV && (sa_q ^ sb_q))
               ? -quo_n : quo_n;
  assign rem_f = (op_q == MDU_DIV && sa_q)
               ? -rem_n : rem_n;

  assign last = cnt_q == 6'(ITER - 1);

  // Next-state, datapath and handshake outputs
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy    = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          busy  = 1'b1;
          op_d  = mdu_op_e'(bus.op);
          a_d   = abs_a;
          b_d   = abs_b;
          sa_d  = is_signed & bus.src_a[W-1];
          sb_d  = is_signed & bus.src_b[W-1];
          cnt_d = '0;
          if (bus.op[1]) begin
            acc_d = {{W{1'b0}}, abs_a};
            if (bus.src_b == '0) begin
              state_d = S_DONE;
              hi_d    = bus.src_a;
              lo_d    = '1;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            acc_d   = {{W{1'b0}}, abs_b};
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        busy  = 1'b1;
        acc_d = mul_n;
        cnt_d = cnt_q + 6'd1;
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else if (last) begin
          state_d      = S_DONE;
          {hi_d, lo_d} = prod;
        end
      end
      S_DIV: begin
        busy  = 1'b1;
        acc_d = {rem_n, quo_n};
        cnt_d = cnt_q + 6'd1;
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else if (last) begin
          state_d = S_DONE;
          hi_d    = rem_f;
          lo_d    = quo_f;
        end
      end
      S_DONE: begin
        we      = ~bus.cancel;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= MDU_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.hi_we    = we;
  assign bus.lo_we    = we;
  assign bus.hi_wdata = hi_q;
  assign bus.lo_wdata = lo_q;

endmodule

// File: tb/tb_mdu_hilo_writer.sv
// Directed bench for mdu_hilo_writer: results,
// latency, divide-by-zero, cancel and reset abort.
module tb_mdu_hilo_writer;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  mdu_hilo_writer_if bus();

  mdu_hilo_writer #(.DATA_W(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.cancel = 1'b0;
  endtask

  // Called at the negedge of the accept cycle T.
  task automatic watch(input string tag,
                       input logic [31:0] eh,
                       input logic [31:0] el,
                       input int lat);
    int nb = 0;
    int nw = 0;
    int k  = -1;
    bit drop = 1'b0;
    for (int c = 0; c < lat + 4; c++) begin
      #1;
      if (bus.busy) nb++;
      if (bus.hi_we !== bus.lo_we)
        chk({tag, "_we_pair"}, bus.hi_we, bus.lo_we);
      if (bus.hi_we) begin
        nw++;
        k = c;
        chk({tag, "_hi"}, bus.hi_wdata, eh);
        chk({tag, "_lo"}, bus.lo_wdata, el);
        drop = 1'b1;
      end
      @(negedge clk);
      if (c == 0) begin
        bus.src_a = 32'hDEAD_BEEF;
        bus.src_b = 32'h0;
      end
      if (drop) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk({tag, "_busy_cycles"}, nb, lat);
    chk({tag, "_write_cycle"}, k, lat);
    chk({tag, "_writes"}, nw, 1);
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input int lat);
    @(negedge clk);
    drive(op, a, b);
    watch(tag, eh, el, lat);
  endtask

  initial begin
    int nw;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.cancel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_we", {bus.hi_we, bus.lo_we}, 0);
    chk("rst_hi", bus.hi_wdata, 0);
    chk("rst_lo", bus.lo_wdata, 0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFE,
           32'h0000_0001, 33);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD,
           32'h0000_0007, 32'hFFFF_FFFF,
           32'hFFFF_FFEB, 33);
    run_op("mult_min", 2'b00, 32'h8000_0000,
           32'h8000_0000, 32'h4000_0000,
           32'h0000_0000, 33);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9,
           32'h0000_0002, 32'hFFFF_FFFF,
           32'hFFFF_FFFD, 33);
    run_op("div_negb", 2'b10, 32'h0000_0007,
           32'hFFFF_FFFE, 32'h0000_0001,
           32'hFFFF_FFFD, 33);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7,
           32'h0000_0002, 32'h0000_000E, 33);
    run_op("div_ovf", 2'b10, 32'h8000_0000,
           32'hFFFF_FFFF, 32'h0000_0000,
           32'h8000_0000, 33);
    run_op("divu_by0", 2'b11, 32'h0000_1234,
           32'h0, 32'h0000_1234,
           32'hFFFF_FFFF, 1);
    run_op("div_by0", 2'b10, 32'hFFFF_FFF0,
           32'h0, 32'hFFFF_FFF0,
           32'hFFFF_FFFF, 1);

    // Cancel mid-divide, then restart at T+11
    nw = 0;
    @(negedge clk);
    drive(2'b10, 32'd1000, 32'd3);
    for (int c = 0; c < 11; c++) begin
      if (c == 10) bus.cancel = 1'b1;
      #1;
      if (bus.hi_we || bus.lo_we) nw++;
      @(negedge clk);
    end
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    #1;
    chk("cancel_busy", bus.busy, 0);
    chk("cancel_nowrite", nw, 0);
    drive(2'b11, 32'd100, 32'd7);
    watch("after_cancel", 32'h2, 32'hE, 33);

    // Cancel arriving in the DONE cycle
    nw = 0;
    @(negedge clk);
    drive(2'b01, 32'h0001_2345, 32'h0001_0000);
    repeat (33) @(negedge clk);
    bus.cancel = 1'b1;
    #1;
    chk("done_cancel_we", {bus.hi_we, bus.lo_we}, 0);
    @(negedge clk);
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.hi_we || bus.lo_we) nw++;
      @(negedge clk);
    end
    chk("done_cancel_after", nw, 0);
    chk("done_cancel_data", {bus.hi_wdata, bus.lo_wdata},
        64'h0000_0001_2345_0000);

    // Reset at T+5 aborts a multiply
    nw = 0;
    @(negedge clk);
    drive(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_hi", bus.hi_wdata, 0);
    chk("rst_mid_lo", bus.lo_wdata, 0);
    for (int c = 0; c < 40; c++) begin
      if (bus.hi_we || bus.lo_we) nw++;
      @(negedge clk);
      #1;
    end
    chk("rst_mid_nowrite", nw, 0);
    @(negedge clk);
    drive(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    watch("after_rst", 32'hFFFF_FFFF,
          32'hFFFF_FFEB, 33);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
